// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: PC -> MAR -> memory read -> MDR -> IR, one bus read per IR word.
// Define IFETCH_TIMEOUT_EN to build the memory-response timeout and its sticky FAULT state.
module ifetch_ctrl #(
  parameter int unsigned IR_WORDS       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned WSEL_W        = (IR_WORDS > 1) ? $clog2(IR_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic              MFC,
  output logic              PCoutEN,
  output logic              marIn,
  output logic              memEN,
  output logic              RW,
  output logic              mdReadEN,
  output logic              mdrOut,
  output logic              IRin,
  output logic              pcInc,
  output logic [WSEL_W-1:0] wordSel,
  output logic              busy,
  output logic              fault
);

  localparam logic [WSEL_W-1:0] WSEL_LAST = WSEL_W'(IR_WORDS - 1);

  typedef enum logic [2:0] {
    ST_START      = 3'd0,
    ST_FETCH_ADDR = 3'd1,
    ST_MEM_REQ    = 3'd2,
    ST_LOAD_IR    = 3'd3,
    ST_EXEC_WAIT  = 3'd4
`ifdef IFETCH_TIMEOUT_EN
    , ST_FAULT    = 3'd5
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [WSEL_W-1:0] wsel_q, wsel_d;

`ifdef IFETCH_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo;

  assign tmo = (cnt_q == CNT_LAST);
`else
  // Timeout length only matters when the timeout logic is built.
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // State register, word index and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_START;
      wsel_q  <= '0;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wsel_q  <= wsel_d;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic; MFC only matters in MEM_REQ, done only in EXEC_WAIT.
  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
`ifdef IFETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_START: state_d = ST_FETCH_ADDR;
      ST_FETCH_ADDR: begin
        state_d = ST_MEM_REQ;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_MEM_REQ: begin
        if (MFC) begin
          state_d = ST_LOAD_IR;
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (tmo) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_LOAD_IR: begin
        if (wsel_q != WSEL_LAST) begin
          wsel_d  = wsel_q + WSEL_W'(1);
          state_d = ST_FETCH_ADDR;
        end else begin
          state_d = ST_EXEC_WAIT;
        end
      end
      ST_EXEC_WAIT: begin
        if (done) begin
          wsel_d  = '0;
          state_d = ST_FETCH_ADDR;
        end
      end
`ifdef IFETCH_TIMEOUT_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_START;
    endcase
  end

  // Moore strobe decode.
  always_comb begin
    PCoutEN  = 1'b0;
    marIn    = 1'b0;
    memEN    = 1'b0;
    RW       = 1'b0;
    mdReadEN = 1'b0;
    mdrOut   = 1'b0;
    IRin     = 1'b0;
    pcInc    = 1'b0;
    busy     = 1'b0;
    fault    = 1'b0;
    unique case (state_q)
      ST_FETCH_ADDR: begin
        PCoutEN = 1'b1;
        marIn   = 1'b1;
        busy    = 1'b1;
      end
      ST_MEM_REQ: begin
        memEN    = 1'b1;
        RW       = 1'b1;
        mdReadEN = 1'b1;
        busy     = 1'b1;
      end
      ST_LOAD_IR: begin
        mdrOut = 1'b1;
        IRin   = 1'b1;
        pcInc  = 1'b1;
        busy   = 1'b1;
      end
`ifdef IFETCH_TIMEOUT_EN
      ST_FAULT: fault = 1'b1;
`endif
      default: ;
    endcase
  end

  assign wordSel = wsel_q;

  a_read_only: assert property (@(posedge clk) disable iff (!rst) memEN |-> RW);
  a_wsel_range: assert property (@(posedge clk) disable iff (!rst) wsel_q <= WSEL_LAST);

endmodule
